// File: rtl/reconf_ctrl.sv
// Partial-reconfiguration controller: quiesces a region, isolates it while a bitstream
// loads, then releases it and reports the newly active module ID.
module reconf_ctrl #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [1:0]       target_rrid,
  input  logic [CNT_W-1:0] cfg_len,
  output logic             rc_reqn,
  input  logic             rc_ackn,
  output logic             is_reconfn,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       active_rrid
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMax = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StLoad, StRelease} state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [CNT_W-1:0] lcnt_q, lcnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [1:0]       rrid_q, rrid_d;
  logic [1:0]       active_q, active_d;
  logic             done_d, err_d;
  logic             rc_reqn_q, is_reconfn_q, busy_q, done_q, err_q;

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    lcnt_d   = lcnt_q;
    len_d    = len_q;
    rrid_d   = rrid_q;
    active_d = active_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          rrid_d  = target_rrid;
          len_d   = cfg_len;
          tcnt_d  = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        // An acknowledge arriving on the expiry cycle still wins.
        if (!rc_ackn) begin
          lcnt_d  = (len_q == '0) ? CNT_W'(1) : len_q;
          state_d = StLoad;
        end else if (tcnt_q == TMax) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      StLoad: begin
        if (lcnt_q <= CNT_W'(1)) begin
          state_d = StRelease;
        end else begin
          lcnt_d = lcnt_q - 1'b1;
        end
      end
      StRelease: begin
        if (rc_ackn) begin
          done_d   = 1'b1;
          active_d = rrid_q;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      tcnt_q       <= '0;
      lcnt_q       <= '0;
      len_q        <= '0;
      rrid_q       <= '0;
      active_q     <= '0;
      rc_reqn_q    <= 1'b1;
      is_reconfn_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      lcnt_q       <= lcnt_d;
      len_q        <= len_d;
      rrid_q       <= rrid_d;
      active_q     <= active_d;
      rc_reqn_q    <= !((state_d == StReq) || (state_d == StLoad));
      is_reconfn_q <= (state_d != StLoad);
      busy_q       <= (state_d != StIdle);
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign rc_reqn     = rc_reqn_q;
  assign is_reconfn  = is_reconfn_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign active_rrid = active_q;

endmodule

// File: tb/tb_reconf_ctrl.sv
// Directed bench for reconf_ctrl: a table of full operations driven by a region
// responder model, plus hand sequences for reset behaviour.
module tb_reconf_ctrl;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic [1:0]       target_rrid;
  logic [CNT_W-1:0] cfg_len;
  logic             rc_reqn;
  logic             rc_ackn;
  logic             is_reconfn;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       active_rrid;

  int passed = 0;
  int total  = 0;

  reconf_ctrl #(
    .TIMEOUT (16),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .target_rrid (target_rrid),
    .cfg_len     (cfg_len),
    .rc_reqn     (rc_reqn),
    .rc_ackn     (rc_ackn),
    .is_reconfn  (is_reconfn),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .active_rrid (active_rrid)
  );

  always #5 clk = ~clk;

  // a: cycles after rc_reqn falls before the region acks (99 = never)
  // r: cycles after rc_reqn rises before the region drops its ack
  // s2k: observation index at which a second start is pulsed (-1 = none)
  typedef struct {
    logic [1:0] rrid;
    int         len;
    int         a;
    int         r;
    int         s2k;
    int         exp_low;
    int         exp_lat;
    int         exp_done;
    int         exp_err;
    logic [1:0] exp_active;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Caller is positioned #1 after a rising edge; start is sampled on the next edge.
  task automatic run_op(input logic [1:0] rrid, input int len, input int a, input int r,
                        input int s2k, output int low, output int dn, output int er,
                        output int lat, output int bad, output int busy_gap);
    int req_cnt, rel_cnt, post;
    bit seen;
    req_cnt = 0; rel_cnt = 0; post = 0; seen = 0;
    low = 0; dn = 0; er = 0; lat = -1; bad = 0; busy_gap = 0;
    start = 1'b1; target_rrid = rrid; cfg_len = CNT_W'(len); rc_ackn = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 80 && post < 4; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      start = (k == s2k);
      if (k == s2k) begin
        target_rrid = rrid ^ 2'd1;
        cfg_len     = CNT_W'(9);
      end
      if (!is_reconfn) low++;
      if (!is_reconfn && rc_reqn) bad++;
      if (done && err) bad++;
      if (done) dn++;
      if (err) er++;
      if (!seen && (done || err)) begin
        seen = 1;
        lat  = k;
      end
      if (!seen && !busy) busy_gap++;
      if (seen) post++;
      if (!rc_reqn) begin
        if (req_cnt == a) rc_ackn = 1'b0;
        req_cnt++;
      end else if (!rc_ackn) begin
        if (rel_cnt == r) rc_ackn = 1'b1;
        rel_cnt++;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int low, dn, er, lat, bad, bgap, pulses;

    vecs[0] = '{2'd2, 5, 3, 2, -1, 5, 12, 1, 0, 2'd2};
    vecs[1] = '{2'd1, 0, 0, 0, -1, 1, 3, 1, 0, 2'd1};
    vecs[2] = '{2'd3, 1, 0, 0, -1, 1, 3, 1, 0, 2'd3};
    vecs[3] = '{2'd1, 3, 14, 0, -1, 3, 19, 1, 0, 2'd1};
    vecs[4] = '{2'd2, 2, 15, 0, -1, 2, 19, 1, 0, 2'd2};
    vecs[5] = '{2'd0, 6, 99, 0, -1, 0, 16, 0, 1, 2'd2};
    vecs[6] = '{2'd0, 4, 0, 0, 2, 4, 6, 1, 0, 2'd0};
    vecs[7] = '{2'd3, 7, 2, 1, -1, 7, 12, 1, 0, 2'd3};
    vecs[8] = '{2'd2, 0, 1, 3, -1, 1, 7, 1, 0, 2'd2};

    rstn = 1'b0; start = 1'b0; target_rrid = '0; cfg_len = '0; rc_ackn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rc_reqn", int'(rc_reqn), 1);
    check("rst_is_reconfn", int'(is_reconfn), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_active", int'(active_rrid), 0);
    // First operation starts on the first edge after reset release.
    rstn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].rrid, vecs[i].len, vecs[i].a, vecs[i].r, vecs[i].s2k,
             low, dn, er, lat, bad, bgap);
      check($sformatf("row%0d_iso_cycles", i), low, vecs[i].exp_low);
      check($sformatf("row%0d_done_pulses", i), dn, vecs[i].exp_done);
      check($sformatf("row%0d_err_pulses", i), er, vecs[i].exp_err);
      check($sformatf("row%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("row%0d_active", i), int'(active_rrid), int'(vecs[i].exp_active));
      check($sformatf("row%0d_bad_combo", i), bad, 0);
      check($sformatf("row%0d_busy_gap", i), bgap, 0);
      check($sformatf("row%0d_end_rc_reqn", i), int'(rc_reqn), 1);
      check($sformatf("row%0d_end_is_reconfn", i), int'(is_reconfn), 1);
      check($sformatf("row%0d_end_busy", i), int'(busy), 0);
    end

    // Reset asserted mid-LOAD aborts without a pulse.
    start = 1'b1; target_rrid = 2'd3; cfg_len = CNT_W'(8); rc_ackn = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort_req_rc_reqn", int'(rc_reqn), 0);
    @(posedge clk); #1;
    check("abort_load_iso", int'(is_reconfn), 0);
    #2 rstn = 1'b0;
    #1;
    check("abort_rc_reqn", int'(rc_reqn), 1);
    check("abort_is_reconfn", int'(is_reconfn), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_err", int'(err), 0);
    check("abort_active", int'(active_rrid), 0);
    rc_ackn = 1'b1;
    pulses = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || err || !is_reconfn || !rc_reqn) pulses++;
    end
    check("abort_quiet", pulses, 0);
    rstn = 1'b1;
    run_op(2'd1, 2, 1, 1, -1, low, dn, er, lat, bad, bgap);
    check("post_abort_iso_cycles", low, 2);
    check("post_abort_done", dn, 1);
    check("post_abort_err", er, 0);
    check("post_abort_latency", lat, 6);
    check("post_abort_active", int'(active_rrid), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
